// File: rtl/clk_rate_ctrl.sv
// clk_rate_ctrl: turns rising edges of one selected divider tap into
// single-cycle CPU clock-enable pulses. Supports full-rate, divided, halt
// and single-step modes, plus a ready/valid tap change that runs through a
// SWITCH state so that no spurious edge is ever produced.
// Optional: define CE_COUNT_EN to add the ce_count pulse counter output.
module clk_rate_ctrl #(
  parameter int unsigned DIV_W       = 32,
  parameter int unsigned SEL_W       = 5,
  parameter int unsigned DEFAULT_SEL = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div_taps,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] sel_req,
  input  logic             sel_valid,
  output logic             sel_ready,
  input  logic             step_req,
  output logic             cpu_ce,
  output logic [SEL_W-1:0] cur_sel,
  output logic             busy,
`ifdef CE_COUNT_EN
  output logic             step_done,
  output logic [31:0]      ce_count
`else
  output logic             step_done
`endif
);

  localparam logic [1:0] MODE_FULL = 2'b00;
  localparam logic [1:0] MODE_DIV  = 2'b01;
  localparam logic [1:0] MODE_HALT = 2'b10;
  localparam logic [1:0] MODE_STEP = 2'b11;

  // Reset tap index, clamped so it always addresses a real tap
  localparam int unsigned DEF_SEL_CLAMP = (DEFAULT_SEL >= DIV_W) ? (DIV_W - 1) : DEFAULT_SEL;
  localparam logic [SEL_W-1:0] RESET_SEL = SEL_W'(DEF_SEL_CLAMP);
  localparam logic [SEL_W-1:0] MAX_SEL   = SEL_W'(DIV_W - 1);

  typedef enum logic {
    RUN    = 1'b0,
    SWITCH = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             tap_q;
  logic             step_q;

  logic [SEL_W-1:0] req_sel_c;
  logic [DIV_W-1:0] cur_shift_c;
  logic [DIV_W-1:0] req_shift_c;
  logic             tap_c;
  logic             req_tap_c;
  logic             tick_c;
  logic             step_edge_c;
  logic             accept_c;

  logic             cpu_ce_nxt;
  logic             step_done_nxt;
  logic             tap_q_nxt;
  logic [SEL_W-1:0] cur_sel_nxt;

  // Tap selection, edge detection and request clamping
  always_comb begin
    req_sel_c   = (32'(sel_req) >= 32'(DIV_W)) ? MAX_SEL : sel_req;
    cur_shift_c = div_taps >> cur_sel;
    req_shift_c = div_taps >> req_sel_c;
    tap_c       = cur_shift_c[0];
    req_tap_c   = req_shift_c[0];
    tick_c      = tap_c & ~tap_q;
    step_edge_c = step_req & ~step_q;
  end

  // Next-state and registered-output values
  always_comb begin
    state_nxt     = state;
    cpu_ce_nxt    = 1'b0;
    step_done_nxt = 1'b0;
    cur_sel_nxt   = cur_sel;
    tap_q_nxt     = tap_c;
    accept_c      = 1'b0;
    case (state)
      RUN: begin
        if (sel_valid) begin
          // Switch wins over any coincident step edge
          accept_c    = 1'b1;
          state_nxt   = SWITCH;
          cur_sel_nxt = req_sel_c;
          tap_q_nxt   = req_tap_c;
        end else begin
          case (mode)
            MODE_FULL: cpu_ce_nxt = 1'b1;
            MODE_DIV:  cpu_ce_nxt = tick_c;
            MODE_HALT: cpu_ce_nxt = 1'b0;
            MODE_STEP: begin
              cpu_ce_nxt    = step_edge_c;
              step_done_nxt = step_edge_c;
            end
            default:   cpu_ce_nxt = 1'b0;
          endcase
        end
      end
      SWITCH: begin
        // Full rate needs no tap alignment; other modes wait for the new tap edge
        if ((mode == MODE_FULL) || tick_c) begin
          state_nxt  = RUN;
          cpu_ce_nxt = (mode == MODE_DIV) && tick_c;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      cpu_ce    <= 1'b0;
      cur_sel   <= RESET_SEL;
      busy      <= 1'b0;
      sel_ready <= 1'b1;
      step_done <= 1'b0;
      tap_q     <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cpu_ce    <= cpu_ce_nxt;
      cur_sel   <= cur_sel_nxt;
      busy      <= (state_nxt == SWITCH);
      sel_ready <= (state_nxt == RUN);
      step_done <= step_done_nxt;
      tap_q     <= tap_q_nxt;
      step_q    <= step_req;
    end
  end

`ifdef CE_COUNT_EN
  // Count delivered enables; cleared when a tap switch is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_count <= 32'd0;
    end else if (accept_c) begin
      ce_count <= 32'd0;
    end else if (cpu_ce) begin
      ce_count <= ce_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/clk_rate_ctrl.md
Name: clk_rate_ctrl

Overview:
- Rate controller between the free-running clock divider and the CPU core.
- Picks one divider tap and turns its rising edges into single-cycle clock-enable pulses for the CPU. The CPU stays on the single `clk` domain; no gated or muxed clocks.
- Supports full-rate, divided, halt and single-step modes.
- Tap changes use a ready/valid request and a glitch-free switch sequence.

Parameters:
- DIV_W, 32, width of the divider tap bus.
- SEL_W, 5, width of the tap-select index.
- DEFAULT_SEL, 2, tap index loaded at reset.

Ports:
- clk  in  1  system clock; the divider runs on the same clock.
- rst_n  in  1  reset, asynchronous, active-low.
- div_taps  in  DIV_W  divider counter bits, synchronous to clk. Bit i has period 2^(i+1) clk.
- mode  in  2  operating mode: 00 full rate, 01 divided, 10 halt, 11 step.
- sel_req  in  SEL_W  requested tap index.
- sel_valid  in  1  tap-change request.
- sel_ready  out  1  controller can accept a tap change.
- step_req  in  1  level input; each rising edge requests one step.
- cpu_ce  out  1  CPU clock enable.
- cur_sel  out  SEL_W  tap index currently in effect.
- busy  out  1  high while in SWITCH.
- step_done  out  1  one-cycle pulse, coincident with the step's cpu_ce.

Behaviour:
- Reset values: cpu_ce=0, cur_sel=DEFAULT_SEL, busy=0, step_done=0, sel_ready=1, state=RUN, tap_q=0, step_q=0.
- Reset is asynchronous and may occur mid-switch; the controller returns cleanly to the reset values.
- Tap sampling:
  - tap = div_taps[cur_sel]; tap_q is registered from tap every cycle.
  - tick = tap & ~tap_q.
  - A sel_req or cur_sel value >= DIV_W is clamped to DIV_W-1.
- States:
  - RUN: cpu_ce is registered.
    - mode 00: cpu_ce <= 1.
    - mode 01: cpu_ce <= tick, so it rises one cycle after the tap edge.
    - mode 10: cpu_ce <= 0.
    - mode 11: cpu_ce <= step edge (step_req & ~step_q). step_done <= the same value. The step is independent of the tap.
  - SWITCH: entered when sel_valid && sel_ready.
    - Latch the clamped sel_req into cur_sel; reload tap_q with the new tap value so no spurious edge is seen.
    - cpu_ce=0, busy=1, sel_ready=0; step edges arriving here are discarded.
    - Exit to RUN on the first tick of the new tap. In mode 01 that tick produces cpu_ce the next cycle.
    - In mode 00, exit to RUN after 1 cycle without waiting for a tick.
- Handshake: sel_ready = (state==RUN). A request held while not ready waits. sel_req must stay stable while sel_valid is high and sel_ready is low.
- A mode change takes effect the cycle after it is sampled; mode is never latched.
- Mode 01→00 gives cpu_ce=1 the next cycle. Mode 00→01 drops cpu_ce until the next tick.
- Selecting the same index as cur_sel still runs the full SWITCH sequence.
- Tap 0 in mode 01 gives cpu_ce every 2 cycles (maximum divided rate).
- Simultaneous sel_valid and step edge in RUN, mode 11: the switch wins and the step is dropped.

Optional Feature:
CE_COUNT_EN
- Defined:
  - Adds output ce_count[31:0], a counter of cpu_ce pulses.
  - Reset to 0; wraps from 0xFFFFFFFF to 0.
  - Cleared synchronously on the cycle SWITCH is entered.
- Not defined: port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset release, div_taps from a free counter, mode=01 → cur_sel=2; cpu_ce one cycle every 8 clk, each one cycle after bit2 rises; busy=0.
- Mode=01, request sel_req=4 with sel_valid → sel_ready=0 and busy=1 until the first bit4 rising edge; no cpu_ce in between; then cpu_ce every 32 clk; cur_sel=4.
- Mode=00 → cpu_ce=1 every cycle from the next clk. Switch to mode=10 → cpu_ce=0 the cycle after.
- Mode=11, three step_req rising edges spaced 5 clk apart, one held high 3 cycles → exactly 3 cpu_ce pulses, each matched by step_done, one cycle after each edge.
- sel_req=31 with DIV_W=8 → cur_sel=7; cpu_ce period 256 clk. Assert rst_n=0 mid-SWITCH → cur_sel=2, cpu_ce=0, busy=0 immediately.
- With CE_COUNT_EN, mode=01, tap 0 for 20 clk → ce_count=10. A switch request clears it to 0.
